// File: rtl/instruction_encoder.sv
// Packs RV32I field records into instruction words and writes them to consecutive RAM word addresses.
// One record per cycle; the write strobe follows the accept by one cycle; in_ready is held low outside RUN.
module instruction_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] base_pc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [19:0] in_imm,
  input  logic [11:0] in_target,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [11:0] next_pc,
  output logic        err,
  output logic [11:0] err_addr,
  output logic        full
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [11:0] LAST_PC = 12'hFFF;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        enc_bad;
  logic [31:0] enc_word;

  // Word-address delta; byte offset is delta<<2, so offset bit 0 is never stored.
  logic [11:0] delta;
  logic [12:1] off_b;
  logic [20:1] off_j;
  logic        b_in_range;

  assign delta      = in_target - next_pc;
  assign off_b      = {delta[10:0], 1'b0};
  assign off_j      = {{7{delta[11]}}, delta, 1'b0};
  assign b_in_range = (delta[11] == delta[10]);

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (in_fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: begin
        enc_word = {off_b[12], off_b[10:5], in_rs2, in_rs1, in_funct3,
                    off_b[4:1], off_b[11], in_opcode};
        enc_bad  = !b_in_range;
      end
      FMT_U: enc_word = {in_imm[19:0], in_rd, in_opcode};
      FMT_J: enc_word = {off_j[20], off_j[10:1], off_j[11], off_j[19:12], in_rd, in_opcode};
      default: enc_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else if (accept) begin
      if (enc_bad) begin
        state_d = HALT;
      end else if (next_pc == LAST_PC) begin
        state_d = DONE;
      end
    end
  end

  always_comb begin
    in_ready = (state_q == RUN) && !start;
    accept   = in_valid && in_ready;
  end

  // A write latched on the previous edge is already on the bus, so start/error here cannot cancel it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      next_pc   <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
      full      <= 1'b0;
    end else begin
      mem_we <= accept && !enc_bad;
      if (start) begin
        next_pc <= base_pc;
        err     <= 1'b0;
        full    <= 1'b0;
      end else if (accept) begin
        if (enc_bad) begin
          err      <= 1'b1;
          err_addr <= next_pc;
        end else begin
          mem_addr  <= next_pc;
          mem_wdata <= enc_word;
          next_pc   <= next_pc + 12'd1;
          if (next_pc == LAST_PC) begin
            full <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed literal cases plus randomized traffic against a behavioural model.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_pc;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [19:0] in_imm;
  logic [11:0] in_target;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [11:0] next_pc;
  logic        err;
  logic [11:0] err_addr;
  logic        full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_pc(base_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .next_pc(next_pc), .err(err),
    .err_addr(err_addr), .full(full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {legal, word}; offsets computed with signed integer arithmetic.
  function automatic logic [32:0] model_encode(
    input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [19:0] imm, input logic [11:0] target,
    input logic [11:0] pc);
    int d;
    logic [31:0] o;
    logic [31:0] w;
    logic ok;
    d = (int'(target) - int'(pc) + 4096) % 4096;
    if (d >= 2048) d = d - 4096;
    o  = 32'(d * 4);
    ok = 1'b1;
    w  = '0;
    case (fmt)
      3'd0: w = {f7, rs2, rs1, f3, rd, opc};
      3'd1: w = {imm[11:0], rs1, f3, rd, opc};
      3'd2: w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      3'd3: begin
        w  = {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], opc};
        ok = (d >= -1024) && (d <= 1023);
      end
      3'd4: w = {imm, rd, opc};
      3'd5: w = {o[20], o[10:1], o[11], o[19:12], rd, opc};
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  bit          m_valid = 1'b0;
  bit          m_run;
  logic [11:0] m_pc, m_addr, m_err_addr;
  logic [31:0] m_wdata;
  logic        m_we, m_err, m_full;

  always @(posedge clk) begin
    logic [32:0] r;
    if (rst) begin
      m_valid = 1'b1; m_run = 1'b0; m_pc = '0; m_addr = '0; m_err_addr = '0;
      m_wdata = '0; m_we = 1'b0; m_err = 1'b0; m_full = 1'b0;
    end else if (m_valid) begin
      m_we = 1'b0;
      if (start) begin
        m_pc = base_pc; m_err = 1'b0; m_full = 1'b0; m_run = 1'b1;
      end else if (in_valid && m_run) begin
        r = model_encode(in_fmt, in_opcode, in_funct3, in_funct7, in_rd,
                         in_rs1, in_rs2, in_imm, in_target, m_pc);
        if (!r[32]) begin
          m_err = 1'b1; m_err_addr = m_pc; m_run = 1'b0;
        end else begin
          m_we = 1'b1; m_addr = m_pc; m_wdata = r[31:0];
          if (m_pc == 12'hFFF) begin
            m_full = 1'b1; m_run = 1'b0;
          end
          m_pc = m_pc + 12'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_ready", 32'(in_ready), 32'(m_run && !start));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("next_pc", 32'(next_pc), 32'(m_pc));
      chk("err", 32'(err), 32'(m_err));
      if (m_err) chk("err_addr", 32'(err_addr), 32'(m_err_addr));
      chk("full", 32'(full), 32'(m_full));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic set_rec(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [19:0] imm, input logic [11:0] tgt);
    in_fmt = fmt; in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_target = tgt; in_valid = 1'b1;
  endtask

  task automatic do_start(input logic [11:0] base);
    start = 1'b1; base_pc = base; in_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_next_pc"}, 32'(next_pc), 32'd0);
    chk({tag, "_err_addr"}, 32'(err_addr), 32'd0);
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] rnd;
    rst = 1'b1; start = 1'b0; base_pc = '0; in_valid = 1'b0;
    set_rec(3'd0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 20'h0, 12'h000);
    in_valid = 1'b0;

    r = model_encode(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 20'h0, 12'h000, 12'h010);
    chk("model_R", r[31:0], 32'h002081B3);
    r = model_encode(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 20'h00FFF, 12'h000, 12'h011);
    chk("model_I", r[31:0], 32'hFFF00293);
    r = model_encode(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 20'h0, 12'h00E, 12'h010);
    chk("model_B", r[31:0], 32'hFE208CE3);
    r = model_encode(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h0, 12'h004, 12'h000);
    chk("model_J", r[31:0], 32'h010000EF);
    r = model_encode(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 20'h0, 12'h400, 12'h000);
    chk("model_B_range", 32'(r[32]), 32'd0);

    repeat (2) step();
    @(negedge clk);
    chk_reset_state("reset");
    step();
    rst = 1'b0;

    // R then back-to-back I
    do_start(12'h010);
    set_rec(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 20'h0, 12'h000);
    step();
    set_rec(3'd1, 7'h13, 3'd0, 7'h55, 5'd5, 5'd0, 5'd0, 20'h00FFF, 12'h000);
    @(negedge clk);
    chk("r_we", 32'(mem_we), 32'd1);
    chk("r_addr", 32'(mem_addr), 32'h010);
    chk("r_wdata", mem_wdata, 32'h002081B3);
    chk("r_next_pc", 32'(next_pc), 32'h011);
    step();
    idle();
    @(negedge clk);
    chk("i_we", 32'(mem_we), 32'd1);
    chk("i_addr", 32'(mem_addr), 32'h011);
    chk("i_wdata", mem_wdata, 32'hFFF00293);

    // Branch and jump offsets
    do_start(12'h010);
    set_rec(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 20'h0, 12'h00E);
    step();
    idle();
    @(negedge clk);
    chk("beq_wdata", mem_wdata, 32'hFE208CE3);
    do_start(12'h000);
    set_rec(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h0, 12'h004);
    step();
    idle();
    @(negedge clk);
    chk("jal_wdata", mem_wdata, 32'h010000EF);

    // Out-of-range branch halts, restart resumes
    do_start(12'h000);
    set_rec(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 20'h0, 12'h400);
    step();
    @(negedge clk);
    chk("berr_err", 32'(err), 32'd1);
    chk("berr_err_addr", 32'(err_addr), 32'h000);
    chk("berr_in_ready", 32'(in_ready), 32'd0);
    chk("berr_we", 32'(mem_we), 32'd0);
    chk("berr_next_pc", 32'(next_pc), 32'h000);
    step();
    idle();
    do_start(12'h020);
    @(negedge clk);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
    set_rec(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 20'h0, 12'h000);
    step();
    idle();
    @(negedge clk);
    chk("restart_we", 32'(mem_we), 32'd1);
    chk("restart_addr", 32'(mem_addr), 32'h020);

    // Session end at 0xFFF
    do_start(12'hFFE);
    set_rec(3'd4, 7'h37, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 20'hABCDE, 12'h000);
    step();
    @(negedge clk);
    chk("full1_addr", 32'(mem_addr), 32'hFFE);
    step();
    @(negedge clk);
    chk("full2_addr", 32'(mem_addr), 32'hFFF);
    chk("full2_we", 32'(mem_we), 32'd1);
    chk("full2_full", 32'(full), 32'd1);
    step();
    @(negedge clk);
    chk("full3_we", 32'(mem_we), 32'd0);
    chk("full3_ready", 32'(in_ready), 32'd0);
    chk("full3_next_pc", 32'(next_pc), 32'h000);
    idle();

    // start during a pending write
    do_start(12'h050);
    set_rec(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 20'h0, 12'h000);
    step();
    start = 1'b1; base_pc = 12'h100;
    @(negedge clk);
    chk("pend_we", 32'(mem_we), 32'd1);
    chk("pend_addr", 32'(mem_addr), 32'h050);
    chk("pend_ready", 32'(in_ready), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("pend_after_we", 32'(mem_we), 32'd0);
    chk("pend_next_pc", 32'(next_pc), 32'h100);

    // Reset mid-stream drops the pending write
    do_start(12'h200);
    set_rec(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd4, 5'd9, 20'h00F3C, 12'h000);
    repeat (2) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk_reset_state("midrst");
    idle();
    step();
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) base_pc = 12'hFF0 + 12'($urandom_range(0, 15));
      else base_pc = 12'($urandom_range(0, 4095));
      rnd = $urandom;
      in_opcode = rnd[6:0]; in_funct3 = rnd[9:7]; in_funct7 = rnd[16:10];
      in_rd = rnd[21:17]; in_rs1 = rnd[26:22]; in_rs2 = rnd[31:27];
      rnd = $urandom;
      in_imm = rnd[19:0];
      if ($urandom_range(0, 9) == 0) in_fmt = 3'(6 + $urandom_range(0, 1));
      else in_fmt = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) in_target = 12'($urandom_range(0, 4095));
      else in_target = m_pc + 12'($urandom_range(0, 2047)) - 12'd1024;
      in_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming RISC-V RV32I instruction encoder and program writer: the inverse of the instruction decoder. It accepts field-level instruction records over a valid/ready handshake, packs each record into a 32-bit instruction word, and writes it to instruction memory at consecutive 12-bit word addresses. For B-type and J-type records it derives the PC-relative offset from an absolute target word address, using the word-address convention the decoder uses for `branch_addr` and `jal_addr`. It sits between a boot/program-load source (UART loader, test harness) and the instruction RAM write port.

## Interface
- No parameters; widths are fixed by RV32I and the 12-bit PC.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: open a new session at `base_pc`, clearing `err`/`full`
- base_pc  in  12  first word address of the session
- in_valid  in  1  record valid
- in_ready  out  1  record accepted when `in_valid && in_ready`
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- in_opcode  in  7; in_funct3  in  3; in_funct7  in  7
- in_rd, in_rs1, in_rs2  in  5 each
- in_imm  in  20  I/S use [11:0]; U uses [19:0]
- in_target  in  12  absolute word address for B/J
- mem_we  out  1  instruction RAM write strobe
- mem_addr  out  12  write word address
- mem_wdata  out  32  encoded instruction
- next_pc  out  12  write pointer (address of the next accepted record)
- err  out  1  sticky encoding error
- err_addr  out  12  PC of the rejected record
- full  out  1  session reached address 0xFFF

## Operation
- States: IDLE (after reset), RUN, HALT (error), DONE (full).
- `in_ready = (state==RUN) && !start`.
- `start` in any state: `next_pc<=base_pc`, `err<=0`, `full<=0`, state → RUN.
- Accept: latch the encoding of the record at PC=`next_pc`; `next_pc<=next_pc+1`.
- Encodings, with imm=`in_imm`:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - U: {imm[19:0], rd, opcode}
- Branch/jump offset:
  - delta = `in_target - PC`, 12-bit, mod 4096, read as signed.
  - Byte offset off = sext(delta)<<2.
  - B: off is 13 bit: {off[12], off[10:5], rs2, rs1, funct3, off[4:1], off[11], opcode}.
  - J: off is 21 bit: {off[20], off[10:1], off[11], off[19:12], rd, opcode}.
- B range: delta must lie in −1024..1023 (delta[11]==delta[10]). J: every 12-bit delta is legal.
- Error (fmt 6/7, or B out of range):
  - Nothing is written; `next_pc` does not advance.
  - `err<=1`, `err_addr<=PC`, state → HALT.
- Accepting at PC 0xFFF: write proceeds, `full<=1`, state → DONE. `next_pc` wraps to 0x000 but is unused until `start`.
- Unused fields are ignored (for example `in_funct7` for an I-type record).

## Timing
- Reset outputs: `in_ready`, `mem_we`, `err`, `full` = 0; `mem_addr`, `mem_wdata`, `next_pc`, `err_addr` = 0; state = IDLE.
- Latency: accept at edge N gives `mem_we=1` with `mem_addr`/`mem_wdata` registered during cycle N+1 for exactly one cycle.
- Throughput: one record per cycle, back-to-back.
- `err`, `full` and the HALT/DONE transitions become visible the cycle after the offending or final accept; `in_ready` is 0 from that cycle on.
- A write already latched completes even if `start` or an error occurs in the same cycle.
- `rst` overrides everything, including a pending write, which is dropped.
- `start` and `in_valid` in the same cycle: no accept.

## Test plan
- R add x3,x1,x2, base_pc=0x010 -> `mem_we` one cycle after accept, `mem_addr` 0x010, `mem_wdata` 0x002081B3, `next_pc` 0x011.
- I addi x5,x0,imm=0xFFF immediately back-to-back with the R record -> consecutive writes; second is 0xFFF00293 at 0x011.
- B beq x1,x2 at PC 0x010, target 0x00E -> 0xFE208CE3. J jal x1 at PC 0x000, target 0x004 -> 0x010000EF.
- B at PC 0x000, target 0x400 -> no write; `err`=1, `err_addr`=0x000, `in_ready`=0. A later `start` clears `err` and resumes.
- base_pc=0xFFE, three valid records -> writes at 0xFFE and 0xFFF only; `full`=1 and the third record is not accepted.
- `start` asserted with `in_valid` while a write is pending -> the pending write completes, the new record is not accepted, and `next_pc` equals the new `base_pc`.
- `rst` mid-stream -> all outputs return to their reset values on the next edge.
